// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller. It steps through the enabled digits one slot at a time,
// with dead-time blanking, PWM brightness and blink gating, and drives registered digit/segment outputs.
module display_scan_ctrl #(
  parameter int SEG_CNT     = 4,
  parameter int FPGA_FREQ   = 50_000_000,
  parameter int SCAN_FREQ   = 1_000,
  parameter int BLANK_CYC   = 64,
  parameter int BRIGHT_W    = 4,
  parameter int BLINK_HZ    = 2,
  parameter bit DIG_ACT_LOW = 1'b0,
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [SEG_CNT-1:0]           en_i,
  input  logic [SEG_CNT-1:0]           blink_i,
  input  logic [SEG_CNT-1:0][7:0]      seg_i,
  input  logic [BRIGHT_W-1:0]          bright_i,
  output logic [SEG_CNT-1:0]           dig_o,
  output logic [7:0]                   seg_o,
  output logic [$clog2(SEG_CNT)-1:0]   active_o,
  output logic                         frame_o
);
  localparam int SLOT_LEN  = FPGA_FREQ / (SCAN_FREQ * SEG_CNT);
  localparam int CNT_W     = $clog2(SLOT_LEN);
  localparam int ACT_W     = $clog2(SEG_CNT);
  localparam int BLINK_LEN = FPGA_FREQ / (2 * BLINK_HZ);
  localparam int BL_W      = (BLINK_LEN > 1) ? $clog2(BLINK_LEN) : 1;

  localparam logic [CNT_W-1:0] SLOT_END = CNT_W'(SLOT_LEN - 1);
  localparam logic [CNT_W-1:0] BLANK_V  = CNT_W'(BLANK_CYC);
  localparam logic [BL_W-1:0]  BL_END   = BL_W'(BLINK_LEN - 1);
  localparam logic [ACT_W:0]   SUM_LIM  = (ACT_W+1)'(SEG_CNT);

  if (SLOT_LEN < BLANK_CYC + 2**BRIGHT_W) begin : g_bad_slot
    $error("display_scan_ctrl: slot too short for blanking plus one PWM period");
  end
  if (SEG_CNT < 2) begin : g_bad_cnt
    $error("display_scan_ctrl: SEG_CNT must be at least 2");
  end

  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                slot_end;
  logic [ACT_W-1:0]    active, act_nxt, act_load;
  logic [ACT_W:0]      sum;
  logic [ACT_W-1:0]    idx;
  logic                frame;
  logic [BRIGHT_W-1:0] pwm;
  logic [BL_W-1:0]     bcnt;
  logic                phase;
  logic [7:0]          pat_s;
  logic [BRIGHT_W-1:0] br_s;
  logic                blk_s, en_s;
  logic                lit;
  logic [SEG_CNT-1:0]  dig_sel, dig_q;
  logic [7:0]          seg_q;

  assign slot_end = (cnt == SLOT_END);
  assign cnt_nxt  = slot_end ? '0 : cnt + 1'b1;

  // Nearest enabled digit after the current one, wrapping; k=SEG_CNT revisits
  // the current digit, and with nothing enabled the index holds.
  always_comb begin
    act_nxt = active;
    sum     = '0;
    idx     = '0;
    for (int k = SEG_CNT; k >= 1; k--) begin
      sum = {1'b0, active} + (ACT_W+1)'(k);
      idx = (sum >= SUM_LIM) ? ACT_W'(sum - SUM_LIM) : sum[ACT_W-1:0];
      if (en_i[idx]) act_nxt = idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      active <= '0;
      frame  <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      frame <= 1'b0;
      if (slot_end) begin
        active <= act_nxt;
        frame  <= (|en_i) && (act_nxt <= active);
      end
    end
  end

  // Slot-start snapshot; reset loads digit 0 so the first slot is ready on release.
  assign act_load = rst_i ? '0 : act_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i || slot_end) begin
      pat_s <= seg_i[act_load];
      br_s  <= bright_i;
      blk_s <= blink_i[act_load];
      en_s  <= en_i[act_load];
    end
  end

  // PWM restarts at zero on the first ON clock of every slot.
  always_ff @(posedge clk_i) begin
    if (rst_i || (cnt_nxt <= BLANK_V)) pwm <= '0;
    else                               pwm <= pwm + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BL_END) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt  <= bcnt + 1'b1;
    end
  end

  assign lit = (cnt >= BLANK_V) && en_s && (|en_i) &&
               ((&br_s) || (pwm < br_s)) && !(blk_s && phase);

  for (genvar g = 0; g < SEG_CNT; g++) begin : g_sel
    assign dig_sel[g] = lit && (active == ACT_W'(g));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dig_q <= '0;
      seg_q <= '0;
    end else begin
      dig_q <= dig_sel;
      seg_q <= lit ? pat_s : 8'h00;
    end
  end

  assign dig_o    = dig_q ^ {SEG_CNT{DIG_ACT_LOW}};
  assign seg_o    = seg_q ^ {8{SEG_ACT_LOW}};
  assign active_o = active;
  assign frame_o  = frame;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus randomized traffic against a cycle-level
// behavioural model (slot position, %-derived PWM and time-derived blink phase).
module tb_display_scan_ctrl;
  localparam int SEG   = 4;
  localparam int FREQ  = 64_000;
  localparam int SCAN  = 1_000;
  localparam int BLANK = 2;
  localparam int BW    = 2;
  localparam int BHZ   = 250;
  localparam int SLOT  = FREQ / (SCAN * SEG);
  localparam int BPH   = FREQ / (2 * BHZ);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, rst2;
  logic [SEG-1:0]      en, blink, en2, blink2;
  logic [SEG-1:0][7:0] seg, seg2;
  logic [BW-1:0]       bright, bright2;
  logic [SEG-1:0]      dig, dig2;
  logic [7:0]          sego, sego2;
  logic [1:0]          act, act2;
  logic                frame, frame2;

  int n_cmp = 0;
  int n_err = 0;

  display_scan_ctrl #(.SEG_CNT(SEG), .FPGA_FREQ(FREQ), .SCAN_FREQ(SCAN), .BLANK_CYC(BLANK),
    .BRIGHT_W(BW), .BLINK_HZ(BHZ), .DIG_ACT_LOW(1'b0), .SEG_ACT_LOW(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .blink_i(blink), .seg_i(seg), .bright_i(bright),
    .dig_o(dig), .seg_o(sego), .active_o(act), .frame_o(frame));

  display_scan_ctrl #(.SEG_CNT(SEG), .FPGA_FREQ(FREQ), .SCAN_FREQ(SCAN), .BLANK_CYC(BLANK),
    .BRIGHT_W(BW), .BLINK_HZ(BHZ), .DIG_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b0)) u_dut_n (
    .clk_i(clk), .rst_i(rst2), .en_i(en2), .blink_i(blink2), .seg_i(seg2), .bright_i(bright2),
    .dig_o(dig2), .seg_o(sego2), .active_o(act2), .frame_o(frame2));

  // Reference model: slot position and global time since release, rules applied with plain arithmetic.
  int             m_pos, m_act, m_t;
  logic [7:0]     m_pat;
  int             m_br;
  bit             m_blk, m_ens, m_frame;
  logic [SEG-1:0] exp_dig;
  logic [7:0]     exp_seg;
  logic [1:0]     exp_act;

  always @(posedge clk) begin
    bit lit;
    int nxt, j;
    if (rst) begin
      m_pos = 0; m_act = 0; m_t = 0; m_frame = 0;
      exp_dig = '0; exp_seg = '0;
      m_pat = seg[0]; m_br = int'(bright); m_blk = blink[0]; m_ens = en[0];
    end else begin
      lit = (m_pos >= BLANK) && m_ens && (en != 0) &&
            (m_br == (1 << BW) - 1 || ((m_pos - BLANK) % (1 << BW)) < m_br) &&
            !(m_blk && ((m_t / BPH) % 2 == 1));
      exp_dig = lit ? (SEG'(1) << m_act) : '0;
      exp_seg = lit ? m_pat : 8'h00;
      m_t++;
      if (m_pos == SLOT - 1) begin
        m_pos = 0;
        nxt = m_act;
        for (int k = SEG; k >= 1; k--) begin
          j = (m_act + k) % SEG;
          if (en[j]) nxt = j;
        end
        m_frame = (en != 0) && (nxt <= m_act);
        m_act = nxt;
        m_pat = seg[m_act]; m_br = int'(bright); m_blk = blink[m_act]; m_ens = en[m_act];
      end else begin
        m_pos++;
        m_frame = 0;
      end
    end
    exp_act = 2'(m_act);
  end

  task automatic apply_reset(input int n);
    @(negedge clk); rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 4'b1111; bright = 2'b11; blink = '0; seg = {8'h4F, 8'h5B, 8'h06, 8'h3F};
    @(negedge clk); rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({dig, sego, act, frame} !== 15'd0) begin
        n_err++;
        $display("FAIL reset_hold got dig=%b seg=%h act=%0d frame=%b want all 0", dig, sego, act, frame);
      end
    end
    rst = 1'b0;
    begin
      int c0 = 0;
      for (int n = 0; n < SLOT; n++) begin
        @(negedge clk);
        if (n == 0) begin
          n_cmp++;
          if (act !== 2'd0 || dig !== 4'b0000) begin
            n_err++;
            $display("FAIL first_slot_start got act=%0d dig=%b want act=0 dig=0000", act, dig);
          end
        end
        if (n == SLOT - 1) begin
          n_cmp++;
          if (act !== 2'd1) begin
            n_err++;
            $display("FAIL first_slot_len got act=%0d want 1", act);
          end
        end
        if (dig == 4'b0001) c0++;
      end
      n_cmp++;
      if (c0 !== SLOT - BLANK) begin
        n_err++;
        $display("FAIL first_slot_lit got %0d want %0d", c0, SLOT - BLANK);
      end
    end
  endtask

  task automatic test_scan(input logic [3:0] en_v, input int f_int, input int n_frames, input int n_lit);
    int last_f = -1, nf = 0, nl = 0;
    en = en_v; bright = 2'b11; blink = '0; seg = {8'h66, 8'h4F, 8'h5B, 8'h06};
    apply_reset(2);
    for (int n = 0; n < 320; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({dig, sego, act, frame} !== {exp_dig, exp_seg, exp_act, m_frame}) begin
        n_err++;
        $display("FAIL scan_%b n=%0d got dig=%b seg=%h act=%0d fr=%b want dig=%b seg=%h act=%0d fr=%b",
                 en_v, n, dig, sego, act, frame, exp_dig, exp_seg, exp_act, m_frame);
      end
      if (n >= SLOT - 1 && !en_v[act]) begin
        n_cmp++; n_err++;
        $display("FAIL scan_skip n=%0d got act=%0d want an enabled digit of %b", n, act, en_v);
      end
      if (frame) begin
        if (last_f >= 0) begin
          n_cmp++;
          if (n - last_f !== f_int) begin
            n_err++;
            $display("FAIL frame_interval got %0d want %0d", n - last_f, f_int);
          end
        end
        last_f = n; nf++;
      end
      if (dig != 0) nl++;
    end
    n_cmp++;
    if (nf !== n_frames || nl !== n_lit) begin
      n_err++;
      $display("FAIL scan_counts_%b got frames=%0d lit=%0d want frames=%0d lit=%0d", en_v, nf, nl, n_frames, n_lit);
    end
  endtask

  task automatic test_pwm(input logic [1:0] br, input int want);
    int nl = 0;
    en = 4'b1111; bright = br; blink = '0; seg = {8'h7F, 8'h6D, 8'h66, 8'h4F};
    apply_reset(2);
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({dig, sego} !== {exp_dig, exp_seg}) begin
        n_err++;
        $display("FAIL pwm_%b n=%0d got dig=%b seg=%h want dig=%b seg=%h", br, n, dig, sego, exp_dig, exp_seg);
      end
      if (dig != 0) nl++;
    end
    n_cmp++;
    if (nl !== want) begin
      n_err++;
      $display("FAIL pwm_duty_%b got %0d lit want %0d", br, nl, want);
    end
  endtask

  task automatic test_sample_hold();
    en = 4'b1111; bright = 2'b11; blink = '0; seg = {8'h4F, 8'h5B, 8'h3F, 8'h06};
    apply_reset(2);
    for (int n = 0; n <= 100; n++) begin
      @(negedge clk);
      if (dig == 4'b0010 && n >= SLOT && n < 2 * SLOT) begin
        n_cmp++;
        if (sego !== 8'h3F) begin
          n_err++;
          $display("FAIL hold_mid_slot n=%0d got seg=%h want 3f", n, sego);
        end
      end
      if (dig == 4'b0010 && n >= 5 * SLOT && n < 6 * SLOT) begin
        n_cmp++;
        if (sego !== 8'h06) begin
          n_err++;
          $display("FAIL hold_next_slot n=%0d got seg=%h want 06", n, sego);
        end
      end
      if (n == 20) seg[1] = 8'h06;
    end
  endtask

  task automatic test_blink();
    int a0 = 0, b0 = 0, t0 = 0, t1 = 0;
    en = 4'b1111; bright = 2'b11; blink = 4'b0001; seg = {8'h07, 8'h7D, 8'h6D, 8'h66};
    apply_reset(2);
    for (int n = 0; n < 4 * BPH; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({dig, sego} !== {exp_dig, exp_seg}) begin
        n_err++;
        $display("FAIL blink n=%0d got dig=%b seg=%h want dig=%b seg=%h", n, dig, sego, exp_dig, exp_seg);
      end
      if (dig[0] && n < BPH) a0++;
      if (dig[0] && n >= BPH && n < 2 * BPH) b0++;
      if (dig[0]) t0++;
      if (dig[1]) t1++;
    end
    n_cmp++;
    if (a0 !== 28 || b0 !== 0 || t0 !== 56 || t1 !== 112) begin
      n_err++;
      $display("FAIL blink_windows got on=%0d off=%0d d0=%0d d1=%0d want 28 0 56 112", a0, b0, t0, t1);
    end
    blink = '0;
  endtask

  task automatic test_random();
    int chg = 1, rst_left = 0;
    apply_reset(1);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({dig, sego, act, frame} !== {exp_dig, exp_seg, exp_act, m_frame}) begin
        n_err++;
        $display("FAIL random n=%0d got dig=%b seg=%h act=%0d fr=%b want dig=%b seg=%h act=%0d fr=%b",
                 n, dig, sego, act, frame, exp_dig, exp_seg, exp_act, m_frame);
      end
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) rst = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; rst_left = $urandom_range(1, 3);
      end
      chg--;
      if (chg == 0) begin
        chg    = $urandom_range(1, 40);
        en     = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
        blink  = 4'($urandom);
        bright = 2'($urandom);
        seg    = $urandom;
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_act_low();
    en2 = 4'b1111; bright2 = 2'b11; blink2 = '0; seg2 = {8'h4F, 8'h5B, 8'h06, 8'h3F};
    @(negedge clk); rst2 = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (dig2 !== 4'b1011 || sego2 !== 8'h5B) begin
      n_err++;
      $display("FAIL act_low_lit got dig=%b seg=%h want 1011 5b", dig2, sego2);
    end
    rst2 = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({dig2, sego2, act2, frame2} !== {4'b1111, 8'h00, 2'd0, 1'b0}) begin
        n_err++;
        $display("FAIL act_low_reset got dig=%b seg=%h act=%0d fr=%b want 1111 00 0 0", dig2, sego2, act2, frame2);
      end
    end
    en2 = 4'b0000; rst2 = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({dig2, sego2, act2, frame2} !== {4'b1111, 8'h00, 2'd0, 1'b0}) begin
        n_err++;
        $display("FAIL act_low_dark n=%0d got dig=%b seg=%h act=%0d fr=%b want 1111 00 0 0",
                 n, dig2, sego2, act2, frame2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = '0; blink = '0; seg = '0; bright = '0;
    rst2 = 1'b1; en2 = '0; blink2 = '0; seg2 = '0; bright2 = '0;
    test_reset();
    test_scan(4'b1111, 4 * SLOT, 5, 280);
    test_scan(4'b1010, 2 * SLOT, 9, 266);
    test_pwm(2'b01, 64);
    test_pwm(2'b00, 0);
    test_sample_hold();
    test_blink();
    test_random();
    test_act_low();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
